// File: rtl/mips_mem_pkg.sv
// Shared constants and lane-steering helpers for the MEM-stage data memory.
// All helpers assume a 32-bit data path with little-endian byte lanes.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // Reserved size encoding 2'b10 falls into the word rules everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = off[0];
            default:   mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << off;
            SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            SIZE_BYTE: d = {4{wd[7:0]}};
            SIZE_HALF: d = {2{wd[15:0]}};
            default:   d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: v = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SIZE_HALF: v = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default:   v = word;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ram_byte_en.sv
// Byte-enabled synchronous RAM: one read-first read/write port plus one read-only port.
// No reset on the array or read registers so synthesis can map it onto block RAM.
module ram_byte_en #(
    parameter int unsigned LEN    = 32,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned NB     = LEN / 8
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [NB-1:0]     be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN-1:0]    wdata_i,
    output logic [LEN-1:0]    rdata_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [LEN-1:0]    dbg_rdata_o
);

    logic [LEN-1:0] mem_q [DEPTH];
    logic [LEN-1:0] rdata_q;
    logic [LEN-1:0] dbg_rdata_q;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < int'(NB); b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        // Read port holds its value while the pipeline is stalled.
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
        dbg_rdata_q <= mem_q[dbg_addr_i];
    end

    assign rdata_o     = rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: rtl/data_mem_stage.sv
// MIPS MEM stage: byte/half/word data memory with load extension, misalignment
// detection and a read-only debug port for memory dumps.
module data_mem_stage
    import mips_mem_pkg::*;
#(
    parameter int unsigned LEN    = 32,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [LEN-1:0]    i_address,
    input  logic [LEN-1:0]    i_write_data,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [LEN-1:0]    o_read_data,
    output logic              o_valid,
    output logic              o_misaligned,
    output logic [LEN-1:0]    o_dbg_data
);

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        offset;
    logic              misaligned;
    logic [3:0]        wr_be;
    logic [LEN-1:0]    wr_data;
    logic [LEN-1:0]    ram_rdata;
    logic [LEN-1:0]    ram_dbg_rdata;
    logic              unused_addr;

    assign word_idx    = i_address[ADDR_W+1:2];
    assign offset      = i_address[1:0];
    assign unused_addr = ^i_address[LEN-1:ADDR_W+2];
    assign misaligned  = is_misaligned(i_size, offset);
    assign wr_data     = store_data(i_size, i_write_data);

    // Reset low also blocks the write so an edge during reset leaves memory intact.
    assign wr_be = (i_rst && i_enable && i_mem_write && !misaligned) ?
                   byte_en(i_size, offset) : 4'b0000;

    ram_byte_en #(
        .LEN   (LEN),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i       (i_clk),
        .en_i        (i_enable),
        .be_i        (wr_be),
        .addr_i      (word_idx),
        .wdata_i     (wr_data),
        .rdata_o     (ram_rdata),
        .dbg_addr_i  (i_dbg_addr),
        .dbg_rdata_o (ram_dbg_rdata)
    );

    logic [1:0] size_d, size_q;
    logic [1:0] off_d, off_q;
    logic       uns_d, uns_q;
    logic       ld_ok_d, ld_ok_q;
    logic       valid_d, valid_q;
    logic       mis_d, mis_q;
    logic       dbg_vld_d, dbg_vld_q;

    always_comb begin
        size_d    = size_q;
        off_d     = off_q;
        uns_d     = uns_q;
        ld_ok_d   = ld_ok_q;
        valid_d   = valid_q;
        mis_d     = mis_q;
        dbg_vld_d = 1'b1;
        if (i_enable) begin
            size_d  = i_size;
            off_d   = offset;
            uns_d   = i_unsigned;
            ld_ok_d = i_mem_read && !misaligned;
            valid_d = i_mem_read;
            mis_d   = (i_mem_read || i_mem_write) && misaligned;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            size_q    <= SIZE_WORD;
            off_q     <= 2'b00;
            uns_q     <= 1'b0;
            ld_ok_q   <= 1'b0;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
            dbg_vld_q <= 1'b0;
        end else begin
            size_q    <= size_d;
            off_q     <= off_d;
            uns_q     <= uns_d;
            ld_ok_q   <= ld_ok_d;
            valid_q   <= valid_d;
            mis_q     <= mis_d;
            dbg_vld_q <= dbg_vld_d;
        end
    end

    // RAM read registers carry no reset; the qualifier flops force zeros instead.
    assign o_read_data  = ld_ok_q ? load_extract(ram_rdata, size_q, uns_q, off_q) : '0;
    assign o_valid      = valid_q;
    assign o_misaligned = mis_q;
    assign o_dbg_data   = dbg_vld_q ? ram_dbg_rdata : '0;

endmodule

// File: doc/data_mem_stage.md
Name: data_mem_stage

Overview:
MEM-stage block of the MIPS pipeline. It holds byte-addressed data memory with byte, halfword and word access, load sign/zero extension and misalignment detection. A second read-only debug port lets the UART debug unit dump memory contents. It sits between the EX/MEM and MEM/WB pipeline registers and presents registered load data to WB.

Parameters:
LEN, 32, data width in bits; must be 32.
DEPTH, 256, number of LEN-bit words; power of two.
ADDR_W, $clog2(DEPTH), localparam; word-index width.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-low
i_enable  in  1  pipeline advance; 0 = stall
i_mem_read  in  1  load in MEM this cycle
i_mem_write  in  1  store in MEM this cycle
i_size  in  2  access size: 00 byte, 01 half, 11 word; 10 reserved, treated as word
i_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
i_address  in  LEN  byte address (ALU result)
i_write_data  in  LEN  store data, right-aligned (rt)
i_dbg_addr  in  ADDR_W  debug word index
o_read_data  out  LEN  extended load data, registered
o_valid  out  1  o_read_data holds a completed load
o_misaligned  out  1  registered flag: access was misaligned
o_dbg_data  out  LEN  debug word, registered

Behaviour:
- Reset (i_rst low, asynchronous): o_read_data=0, o_valid=0, o_misaligned=0, o_dbg_data=0. Memory array is not cleared. No write occurs on any edge while i_rst is low.
- Addressing: word index = i_address[ADDR_W+1:2]. Byte offset = i_address[1:0]. Address bits above ADDR_W+1 are ignored, so accesses wrap modulo DEPTH*4.
- Misaligned access: half with offset[0]=1, or word with offset!=0.
- Store: on a rising edge with i_enable & i_mem_write & aligned, write byte lanes only.
  - byte: lane = offset, data = i_write_data[7:0] replicated.
  - half: lanes {offset+1, offset}, data = i_write_data[15:0] replicated.
  - word: all 4 lanes.
  - Lane 0 = bits [7:0] (little-endian).
- Misaligned store: the write is suppressed. o_misaligned=1 on the next edge.
- Load: synchronous read, latency 1. On an edge with i_enable=1:
  - o_valid <= i_mem_read.
  - o_misaligned <= (i_mem_read|i_mem_write) & misaligned.
  - o_read_data <= extracted and extended value. Byte = lane at offset. Half = lanes at offset[1]. Extension uses the registered i_size, i_unsigned and offset.
- Misaligned load: o_read_data <= 0, o_valid <= 1, o_misaligned <= 1.
- No load (i_mem_read=0, enabled): o_read_data <= 0.
- Stall (i_enable=0): no write; o_read_data, o_valid and o_misaligned hold.
- i_mem_read & i_mem_write both high: the write is performed and the read returns the old word (read-first).
- Read-during-write to the same word, in consecutive or the same edge: read-first semantics.
- Debug port: o_dbg_data <= mem[i_dbg_addr] every edge, independent of i_enable. A same-edge write to the same word returns old data.
- No internal FSM beyond the registers. Throughput is one access per cycle.

Decomposition:
- Package mips_mem_pkg holds:
  - SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b11
  - function for byte-enable generation
  - function for load extraction/extension
- Sub-module ram_byte_en holds the array. It has one read-first write/read port with a 4-bit byte enable and one read-only port, both synchronous, parameters LEN and DEPTH. This lets synthesis infer BRAM.
- data_mem_stage contains alignment logic, lane steering, extension and the output registers.

Test Plan:
- Reset mid-operation: assert i_rst low between edges during a store to 0x10 -> all outputs 0 immediately; mem[4] unchanged; o_dbg_data reads the old value.
- Word store/load: sw 0xDEADBEEF @0x10, then lw @0x10 -> o_read_data=0xDEADBEEF, o_valid=1 one cycle after the load.
- Byte and half extension: with 0xDEADBEEF @0x10:
  - lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE
  - lh @0x10 -> 0xFFFFBEEF; lhu @0x12 -> 0x0000DEAD
- Partial store: sb 0x55 @0x11 -> debug read of index 4 = 0xDEAD55EF; sh 0x1234 @0x12 -> 0x123455EF.
- Misaligned: sw @0x12 -> o_misaligned=1, memory unchanged. lh @0x11 -> o_read_data=0, o_valid=1, o_misaligned=1.
- Stall and wrap:
  - i_enable=0 with sw @0x20 -> no write; outputs hold.
  - With DEPTH=256, store @0x400 -> lands in index 0.
  - Same-edge lw+sw @0x0 -> old data returned.
